// File: rtl/alu_op_scheduler_if.sv
// Bundle of the scheduler's request, ALU-side and response signals.
// slave is the scheduler's view; master is the view of the surrounding
// requesters / ALU / response consumer.
interface alu_op_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
);
  // Requester 0
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic [SEL_W-1:0]   req0_sel;
  // Requester 1
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic [SEL_W-1:0]   req1_sel;
  // Shared ALU
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [SEL_W-1:0]   alu_sel;
  logic [WIDTH-1:0]   alu_c;
  logic               alu_carry;
  logic [2*WIDTH-1:0] alu_mul;
  // Response
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_c;
  logic               rsp_carry;
  logic [2*WIDTH-1:0] rsp_mul;
  logic               busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_c, alu_carry, alu_mul,
    output rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_mul,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_c, alu_carry, alu_mul,
    input  rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_mul,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE; the accepted op's operands are held on
// the ALU for SETTLE_CYCLES, the results are captured and returned tagged
// with the requester id.
//
// Handshakes: every port uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both high; valid, once raised by a source,
// is expected to stay high with stable data until that transfer, and ready
// may depend combinationally on the opposite valid (the request readies do).
module alu_op_scheduler #(
  parameter int WIDTH         = 4,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_scheduler_if.slave   bus,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges
  // after the accept edge.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic               pri;      // requester that wins when both are valid
  logic               tag;      // requester of the op in flight
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SEL_W-1:0]   sel_q;
  logic [WIDTH-1:0]   c_q;
  logic               carry_q;
  logic [2*WIDTH-1:0] mul_q;
  logic               id_q;

  logic               ready0;
  logic               ready1;
  logic               grant0;
  logic               grant1;

  // A requester is blocked only when the other one is valid and holds priority.
  assign ready0 = (state == IDLE) & ~(bus.req1_valid & pri);
  assign ready1 = (state == IDLE) & ~(bus.req0_valid & ~pri);
  assign grant0 = bus.req0_valid & ready0;
  assign grant1 = bus.req1_valid & ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_sel    = sel_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_mul    = mul_q;
  assign bus.busy       = (state != IDLE);
  assign fsm_state      = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP at counter zero,
  // RESP -> IDLE once the consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant0 | grant1) state_nxt = WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, arbitration pointer, settle counter and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri     <= 1'b0;
      tag     <= 1'b0;
      cnt     <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      mul_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            a_q   <= bus.req0_a;
            b_q   <= bus.req0_b;
            sel_q <= bus.req0_sel;
            tag   <= 1'b0;
            pri   <= 1'b1;
            cnt   <= CNT_INIT;
          end else if (grant1) begin
            a_q   <= bus.req1_a;
            b_q   <= bus.req1_b;
            sel_q <= bus.req1_sel;
            tag   <= 1'b1;
            pri   <= 1'b0;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            c_q     <= bus.alu_c;
            carry_q <= bus.alu_carry;
            mul_q   <= bus.alu_mul;
            id_q    <= tag;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
